// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS HI/LO multiply/divide unit.
// Holds opcodes, multiply latency limits and the FSM state encoding.
package mips_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   localparam int MUL_LAT_MIN = 1;
   localparam int MUL_LAT_MAX = 4;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DIVFIX
   } mdState_t;

endpackage

// File: rtl/mips_div_iter.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// done flags the cycle whose edge retires the final iteration.
module mips_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   // Borrow out of the trial subtract means the divisor did not fit.
   assign shifted = {remainder, quotient[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvsr};
   assign done    = busy && (cnt == CW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         cnt       <= '0;
         dvsr      <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else if (start) begin
         busy      <= 1'b1;
         cnt       <= CW'(WIDTH);
         dvsr      <= divisor;
         quotient  <= dividend;
         remainder <= '0;
      end else if (busy) begin
         cnt <= cnt - 1'b1;
         if (cnt == CW'(1))
            busy <= 1'b0;
         if (!diff[WIDTH]) begin
            remainder <= diff[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b1};
         end else begin
            remainder <= shifted[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/mips_muldiv.sv
// HI/LO multiply/divide unit beside the EX-stage ALU.
// Pipelined multiply, iterative divide, Busy stalls HI/LO readers.
module mips_muldiv
   import mips_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 3
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             StartE,
   input  logic [2:0]       OpE,
   input  logic             FlushE,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   output logic             Busy,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : gBadLat
      $error("mips_muldiv: MUL_LAT out of range");
   end
   if (WIDTH < 8 || WIDTH > 64 || (WIDTH % 2) != 0) begin : gBadWidth
      $error("mips_muldiv: illegal WIDTH");
   end

   mdState_t state;

   logic             accept;
   logic             isSigned;
   logic             isDivOp;
   logic [2:0]       mulCnt;
   logic             negQ;
   logic             negR;
   logic [2*WIDTH-1:0] extA;
   logic [2*WIDTH-1:0] extB;
   logic [2*WIDTH-1:0] mulProd;
   logic [2*WIDTH-1:0] mulPipe [MUL_LAT];
   logic [WIDTH-1:0] magA;
   logic [WIDTH-1:0] magB;
   logic [WIDTH-1:0] divQuo;
   logic [WIDTH-1:0] divRem;
   logic [WIDTH-1:0] fixQuo;
   logic [WIDTH-1:0] fixRem;
   logic             divStart;
   logic             divBusy;
   logic             divDone;

   assign accept   = StartE && !FlushE && !Busy;
   assign isSigned = (OpE == MD_MULT) || (OpE == MD_DIV);
   assign isDivOp  = (OpE == MD_DIV) || (OpE == MD_DIVU);
   assign divStart = accept && isDivOp;

   assign extA = isSigned ? {{WIDTH{SrcAE[WIDTH-1]}}, SrcAE}
                          : {{WIDTH{1'b0}}, SrcAE};
   assign extB = isSigned ? {{WIDTH{SrcBE[WIDTH-1]}}, SrcBE}
                          : {{WIDTH{1'b0}}, SrcBE};
   assign mulProd = extA * extB;

   assign magA = (isSigned && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
   assign magB = (isSigned && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

   assign fixQuo = negQ ? -divQuo : divQuo;
   assign fixRem = negR ? -divRem : divRem;

   mips_div_iter #(.WIDTH(WIDTH)) uDiv (
      .clk       (CLK),
      .rst       (Reset),
      .start     (divStart),
      .dividend  (magA),
      .divisor   (magB),
      .busy      (divBusy),
      .done      (divDone),
      .quotient  (divQuo),
      .remainder (divRem)
   );

   // Product enters stage 0 on accept and ripples one stage per cycle.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < MUL_LAT; i++)
            mulPipe[i] <= '0;
      end else begin
         if (accept)
            mulPipe[0] <= mulProd;
         for (int i = 1; i < MUL_LAT; i++)
            mulPipe[i] <= mulPipe[i-1];
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         Busy   <= 1'b0;
         Hi     <= '0;
         Lo     <= '0;
         mulCnt <= '0;
         negQ   <= 1'b0;
         negR   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               case (OpE)
                  MD_MTHI: Hi <= SrcAE;
                  MD_MTLO: Lo <= SrcAE;
                  MD_MULT, MD_MULTU: begin
                     state  <= MUL;
                     Busy   <= 1'b1;
                     mulCnt <= '0;
                  end
                  MD_DIV, MD_DIVU: begin
                     state <= DIV;
                     Busy  <= 1'b1;
                     negQ  <= isSigned && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                     negR  <= isSigned && SrcAE[WIDTH-1];
                  end
                  default: ;
               endcase
            end
            MUL: begin
               if (mulCnt == 3'(MUL_LAT - 1)) begin
                  {Hi, Lo} <= mulPipe[MUL_LAT-1];
                  state    <= IDLE;
                  Busy     <= 1'b0;
               end else begin
                  mulCnt <= mulCnt + 1'b1;
               end
            end
            DIV: if (divDone) state <= DIVFIX;
            DIVFIX: begin
               Lo    <= fixQuo;
               Hi    <= fixRem;
               state <= IDLE;
               Busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   startWhileBusy: assert property (@(posedge CLK) disable iff (Reset)
      !(StartE && !FlushE && Busy))
      else $error("mips_muldiv: StartE while Busy");

   divEngineLive: assert property (@(posedge CLK) disable iff (Reset)
      (state == DIV) |-> divBusy)
      else $error("mips_muldiv: divider idle in DIV");

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Parametrised HI/LO multiply/divide unit for the pipelined MIPS core; sits beside the EX-stage ALU.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multiplies run through a configurable-latency pipeline; divides run on an iterative radix-2 engine.
- Exposes Busy so the hazard unit stalls MFHI/MFLO and any new mul/div until the result lands.

Parameters:
- WIDTH, 32, operand width and HI/LO width; any even value 8..64.
- MUL_LAT, 3, multiply latency in cycles; legal range 1..4.

Ports:
- CLK  in  1  clock; rising edge.
- Reset  in  1  asynchronous, active-high reset.
- StartE  in  1  EX stage holds a valid mul/div/mthi/mtlo op this cycle.
- OpE  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 are no-ops.
- FlushE  in  1  EX bubble; when high, StartE is ignored.
- SrcAE  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- SrcBE  in  WIDTH  rt operand (divisor / multiplier).
- Busy  out  1  operation in flight; HI/LO are not yet valid.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE; Hi=0, Lo=0, Busy=0.
  - In-flight results are discarded.
- Accept condition: StartE & ~FlushE & ~Busy, sampled on a rising edge; call that edge cycle 0.
  - StartE while Busy is ignored. The hazard unit guarantees this never happens; an assertion flags it.
- State machine: IDLE, MUL, DIV, DIVFIX.
- MTHI/MTLO:
  - Stay in IDLE; Hi (or Lo) takes SrcAE at the cycle-0 edge. Busy is never raised.
- MULT/MULTU:
  - IDLE->MUL. Busy is high in cycles 1..MUL_LAT.
  - The full 2*WIDTH product is written at the end of cycle MUL_LAT: {Hi,Lo}=SrcAE*SrcBE, signed or unsigned per OpE.
  - Busy=0 and the new Hi/Lo are visible from cycle MUL_LAT+1; state returns to IDLE.
  - Operands are captured at cycle 0; later changes on SrcAE/SrcBE have no effect.
- DIV/DIVU:
  - IDLE->DIV. Operands are converted to magnitudes (signed op) and captured with their sign bits.
  - DIV runs WIDTH restoring iterations, one per cycle (cycles 1..WIDTH), then DIVFIX (cycle WIDTH+1).
  - DIVFIX applies signs: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Lo=quotient and Hi=remainder are written at the end of DIVFIX. Busy is high in cycles 1..WIDTH+1 and low from WIDTH+2.
  - Quotient truncates toward zero.
- Divide by zero:
  - Completes in normal time with Lo = all ones (unsigned) or +-1 (signed, -1 if dividend is nonnegative, +1 otherwise), and Hi = dividend.
  - No exception is raised.
- Signed overflow (-2^(WIDTH-1) / -1): Lo = -2^(WIDTH-1), Hi = 0, by natural two's-complement wrap.
- Hi/Lo hold their values in all cycles other than the write edges above.
- OpE 6-7 with accept asserted: no state change.
- FlushE arrives only with the op in EX. Once accepted, an operation is never cancelled except by Reset.

Decomposition:
- Shared package mips_pkg holds:
  - The MD_MULT..MD_MTLO opcode localparams.
  - The MUL_LAT legality range.
  - The state encoding (IDLE/MUL/DIV/DIVFIX).
- Sub-module mips_div_iter: unsigned radix-2 restoring divider (start/busy/done, WIDTH iterations); reused by the future FPU.
- The multiply pipeline stays inline as a MUL_LAT-deep shift register.

Test Plan:
- MULT SrcAE=0xFFFFFFFE (-2), SrcBE=3, WIDTH=32, MUL_LAT=3 -> Busy high in cycles 1-3; cycle 4: Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001 at cycle 4.
- DIV -7 / 2 -> Busy for 33 cycles; cycle 34: Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); DIVU 100/7 -> Lo=14, Hi=2.
- DIVU 5/0 -> Lo=0xFFFFFFFF, Hi=5; DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MTHI 0x1234 then MTLO 0x5678 back-to-back -> Hi=0x1234 and Lo=0x5678 visible the following cycles, Busy never set. StartE with FlushE=1 -> no change. StartE during Busy -> ignored, assertion fires.
- Reset asserted mid-DIV (cycle 10) -> Busy, Hi and Lo go to 0 immediately (asynchronously). A new MULTU 3*4 after release -> Lo=12, Hi=0.
